// File: rtl/wb_arbiter.sv
// Two-requester (ALU/LSU) register-file writeback arbiter with a pending-register scoreboard.
// Optional ALU anti-starvation guard is compiled in with macro WB_STARVE_GUARD_EN.
module wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  input  logic        issue_en,
  input  logic [4:0]  issue_rd,
  output logic        reg_write_en,
  output logic [4:0]  adrD,
  output logic [31:0] result,
  output logic [31:0] pending
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("wb_arbiter: STARVE_LIMIT must be in 1..15");
  end

  logic        w_force_alu;
  logic        w_alu_grant;
  logic        w_lsu_grant;
  logic        w_xfer;
  logic        w_wr;
  logic [4:0]  w_rd;
  logic [31:0] w_data;
  logic [31:0] w_pending_next;

  logic        r_wen;
  logic [4:0]  r_adr;
  logic [31:0] r_data;
  logic [31:0] r_pending;

`ifdef WB_STARVE_GUARD_EN
  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve;

  assign w_force_alu = (r_starve == LP_LIMIT);

  // Counts consecutive ALU denials; any ALU transfer or idle ALU restarts the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_starve <= 4'd0;
    end else if (!alu_valid || w_alu_grant) begin
      r_starve <= 4'd0;
    end else if (r_starve != LP_LIMIT) begin
      r_starve <= r_starve + 4'd1;
    end
  end
`else
  assign w_force_alu = 1'b0;
`endif

  always_comb begin
    w_alu_grant = 1'b0;
    w_lsu_grant = 1'b0;
    if (rst) begin
      if (alu_valid && (!lsu_valid || w_force_alu)) begin
        w_alu_grant = 1'b1;
      end else if (lsu_valid) begin
        w_lsu_grant = 1'b1;
      end
    end
  end

  assign alu_ready = w_alu_grant;
  assign lsu_ready = w_lsu_grant;
  assign w_xfer    = w_alu_grant | w_lsu_grant;
  assign w_rd      = w_alu_grant ? alu_rd   : lsu_rd;
  assign w_data    = w_alu_grant ? alu_data : lsu_data;
  assign w_wr      = w_xfer && (w_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wen  <= 1'b0;
      r_adr  <= 5'd0;
      r_data <= 32'd0;
    end else begin
      r_wen <= w_wr;
      if (w_wr) begin
        r_adr  <= w_rd;
        r_data <= w_data;
      end
    end
  end

  // Gating with rst drops a write already staged when reset arrives.
  assign reg_write_en = r_wen & rst;
  assign adrD         = r_adr;
  assign result       = r_data;

  // Clear first, then set, so a new producer of the same register wins.
  always_comb begin
    w_pending_next = r_pending;
    if (w_wr) begin
      w_pending_next[w_rd] = 1'b0;
    end
    if (issue_en && (issue_rd != 5'd0)) begin
      w_pending_next[issue_rd] = 1'b1;
    end
    w_pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pending <= 32'd0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  assign pending = r_pending;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes go into a queue, a negedge monitor checks them.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, issue_en;
  logic [4:0]  alu_rd, lsu_rd, issue_rd;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, reg_write_en;
  logic [4:0]  adrD;
  logic [31:0] result, pending;

  int n_tests = 0;
  int n_fail  = 0;
  bit push_en = 1'b1;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  wb_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .reg_write_en(reg_write_en), .adrD(adrD), .result(result), .pending(pending)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle: drive just after posedge, check readies at negedge, queue expected write.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input logic ie, input logic [4:0] ird,
                      input logic exp_a, input logic exp_l, input string nm);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    issue_en = ie; issue_rd = ird;
    @(negedge clk);
    chk({nm, "_alu_ready"}, {31'd0, alu_ready}, {31'd0, exp_a});
    chk({nm, "_lsu_ready"}, {31'd0, lsu_ready}, {31'd0, exp_l});
    #1;
    if (push_en) begin
      if (exp_a && ard != 5'd0) exp_q.push_back({ard, ad});
      else if (exp_l && lrd != 5'd0) exp_q.push_back({lrd, ld});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, nm);
  endtask

  always @(negedge clk) begin
    if (reg_write_en === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got adrD=%0d result=%h expected no write", adrD, result);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({adrD, result} !== e) begin
          n_fail++;
          $display("FAIL write_data: got adrD=%0d result=%h expected adrD=%0d result=%h",
                   adrD, result, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    issue_en = 1'b0; issue_rd = 5'd0;
    @(posedge clk);
    #1;

    // Reset: requests and issue must be ignored, everything cleared.
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd3, 1'b0, 1'b0, "rst_a");
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd3, 1'b0, 1'b0, "rst_b");
    chk("rst_wen", {31'd0, reg_write_en}, 32'd0);
    chk("rst_adrD", {27'd0, adrD}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_pending", pending, 32'd0);
    rst = 1'b1;

    // Single ALU write, then hold of adrD/result with write strobe low.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, "alu_single");
    idle("alu_single_idle");
    chk("alu_single_wen_low", {31'd0, reg_write_en}, 32'd0);
    chk("alu_single_adr_hold", {27'd0, adrD}, 32'd5);
    chk("alu_single_res_hold", result, 32'hDEADBEEF);

    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h0000_0044, 1'b0, 5'd0, 1'b0, 1'b1, "lsu_only");
    idle("lsu_only_idle");

`ifdef WB_STARVE_GUARD_EN
    for (int i = 1; i <= 5; i++)
      step(1'b1, 5'd9, 32'hB0B0_0009, 1'b1, 5'd7, 32'hA000_0000 + i, 1'b0, 5'd0,
           (i == 4), (i != 4), "contend_guard");
`else
    for (int i = 1; i <= 10; i++)
      step(1'b1, 5'd9, 32'hB0B0_0009, 1'b1, 5'd7, 32'hA000_0000 + i, 1'b0, 5'd0,
           1'b0, 1'b1, "contend_noguard");
`endif

    // Write to x0 is accepted but never reaches the register file.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 1'b0, 1'b1, "x0");
    chk("x0_wen", {31'd0, reg_write_en}, 32'd0);
    chk("x0_pending", pending, 32'd0);

    // Scoreboard set/clear interactions.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0, 1'b0, "sb_issue12");
    chk("sb_set12", pending, 32'h0000_1000);
    step(1'b1, 5'd12, 32'h0000_0C01, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b1, 1'b0, "sb_same");
    chk("sb_set_wins", pending, 32'h0000_1000);
    step(1'b1, 5'd12, 32'h0000_0C02, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, "sb_clr12");
    chk("sb_clear12", pending, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 1'b0, 1'b0, "sb_issue20");
    step(1'b1, 5'd20, 32'h0000_1401, 1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 1'b1, 1'b0, "sb_diff");
    chk("sb_both_applied", pending, 32'h0020_0000);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b0, "sb_issue0");
    chk("sb_issue_x0", pending, 32'h0020_0000);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'h0000_1501, 1'b0, 5'd0, 1'b0, 1'b1, "sb_lsu21");
    chk("sb_clear21", pending, 32'd0);

    // Reset the cycle after a transfer: the staged write must vanish.
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0, 1'b0, "mid_issue6");
    push_en = 1'b0;
    step(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0, "mid_xfer3");
    rst = 1'b0;
    #1;
    chk("mid_wen_suppressed", {31'd0, reg_write_en}, 32'd0);
    idle("mid_rst");
    chk("mid_adrD", {27'd0, adrD}, 32'd0);
    chk("mid_result", result, 32'd0);
    chk("mid_pending", pending, 32'd0);
    rst = 1'b1;
    push_en = 1'b1;

    step(1'b1, 5'd9, 32'hB0B0_0019, 1'b1, 5'd7, 32'hA000_0077, 1'b0, 5'd0, 1'b0, 1'b1, "post_rst");
    idle("end_a");
    idle("end_b");
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3; consecutive ALU denials before the ALU is forced to win (legal range 1..15).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous and active-low, sampled on the rising edge of clk.
REQ-004 SHALL have port alu_valid  in  1  ALU writeback request.
REQ-005 SHALL have port alu_rd  in  5  ALU destination register.
REQ-006 SHALL have port alu_data  in  32  ALU result.
REQ-007 SHALL have port alu_ready  out  1  ALU request accepted this cycle.
REQ-008 SHALL have ports lsu_valid in 1, lsu_rd in 5, lsu_data in 32, lsu_ready out 1: the load/store writeback request with the same meanings as the ALU ports.
REQ-009 SHALL have port issue_en  in  1  an instruction is being issued that has a destination register.
REQ-010 SHALL have port issue_rd  in  5  destination of the issuing instruction.
REQ-011 SHALL have port reg_write_en  out  1  register-file write strobe.
REQ-012 SHALL have port adrD  out  5  register-file write address.
REQ-013 SHALL have port result  out  32  register-file write data.
REQ-014 SHALL have port pending  out  32  scoreboard; bit n high means register n awaits writeback.

Function
REQ-015 A transfer SHALL occur on a requester when its valid and ready are both high in the same cycle.
REQ-016 The ready outputs SHALL be combinational from the valid inputs and the starvation counter, with at most one of them high per cycle.
REQ-017 Grant, only ALU valid: alu_ready=1.
REQ-018 Grant, only LSU valid: lsu_ready=1.
REQ-019 Grant, both valid: lsu_ready=1, unless the starvation counter equals STARVE_LIMIT, in which case alu_ready=1.
REQ-020 Grant, neither valid: both readies SHALL be 0.
REQ-021 The write stage SHALL be registered with 1-cycle latency: a transfer in cycle N drives reg_write_en=1 with adrD and result from the winner in cycle N+1.
REQ-022 If no transfer occurs in cycle N, reg_write_en SHALL be 0 in cycle N+1, and adrD and result SHALL hold their previous values.
REQ-023 A transfer with rd=0 SHALL be accepted (ready=1) but SHALL produce reg_write_en=0 in the next cycle.
REQ-024 Starvation counter (4 bits): SHALL increment when alu_valid=1 and alu_ready=0, and SHALL saturate at STARVE_LIMIT.
REQ-025 The starvation counter SHALL clear on an ALU transfer or whenever alu_valid=0.
REQ-026 Scoreboard set: issue_en=1 with issue_rd≠0 SHALL set pending[issue_rd] at the next edge.
REQ-027 Scoreboard clear: a transfer with rd≠0 SHALL clear pending[rd] at the same edge.
REQ-028 Scoreboard, same register set and cleared in the same cycle: the set SHALL win, since a new producer supersedes the old one.
REQ-029 Scoreboard, set and clear on different registers in the same cycle: both updates SHALL be applied.
REQ-030 pending[0] SHALL be constant 0.
REQ-031 Requesters SHALL hold valid, rd and data stable until their transfer occurs; the arbiter SHALL NOT buffer denied requests.

Reset
REQ-032 While rst=0 at a rising edge, the following SHALL all be 0 after that edge: reg_write_en, adrD, result, pending, and the starvation counter.
REQ-033 While rst=0, alu_ready and lsu_ready SHALL be 0, and no transfer SHALL be counted.
REQ-034 Reset asserted in the cycle after a transfer SHALL suppress that pending register-file write.
REQ-035 The first edge with rst=1 SHALL resume normal arbitration with the counter at 0.

Configuration
REQ-036 Macro WB_STARVE_GUARD_EN SHALL compile the starvation feature in or out.
REQ-037 With WB_STARVE_GUARD_EN defined: the starvation counter and STARVE_LIMIT override SHALL behave as in REQ-019 and REQ-024 to REQ-025.
REQ-038 With WB_STARVE_GUARD_EN undefined: no counter SHALL exist, LSU SHALL always win when both are valid, and STARVE_LIMIT SHALL be ignored.

Verification
REQ-039 Single ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle -> alu_ready=1 that cycle; next cycle reg_write_en=1, adrD=5, result=0xDEADBEEF; the cycle after, reg_write_en=0.
REQ-040 Contention, guard enabled, STARVE_LIMIT=3: both valid continuously, LSU rd=7, ALU rd=9 -> LSU granted for 3 cycles, ALU granted on the 4th, counter back to 0, LSU granted on the 5th.
REQ-041 Contention, guard disabled: both valid for 10 cycles -> lsu_ready=1 and alu_ready=0 for all 10 cycles.
REQ-042 x0 write: lsu_valid=1, lsu_rd=0, lsu_data=0x1234 -> lsu_ready=1; next cycle reg_write_en=0; pending unchanged.
REQ-043 Scoreboard: issue_en=1, issue_rd=12 -> pending[12]=1.
REQ-044 Scoreboard: a later cycle with an ALU transfer to rd=12 and issue_en=1, issue_rd=12 in the same cycle -> pending[12] stays 1.
REQ-045 Scoreboard: a further transfer to rd=12 with no issue -> pending[12]=0.
REQ-046 Reset mid-operation: a transfer to rd=3 in cycle N, then rst=0 in cycle N+1 -> reg_write_en=0 in cycle N+1, and all outputs and pending are 0 after the edge.
